// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: stream header width
// and the loader FSM state encoding.
package mips_pkg;

  localparam int HDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE
  } load_state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Assembles big-endian stream bytes into a 32-bit word; the first byte
// shifted in ends up in the most significant position after four shifts.
module loader_word_asm (
  input  logic        clk,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word
);

  always_ff @(posedge clk) begin
    if (clear) begin
      word <= '0;
    end else if (shift_en) begin
      word <= {word[23:0], byte_in};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory and holds the CPU
// in reset until a complete, in-range program is resident.
module imem_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  load_state_t      state, state_nx;
  logic [HDR_W-1:0] count;
  logic [HDR_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic             err;
  logic             accept;
  logic [HDR_W-1:0] len_full;
  logic [31:0]      word;

  assign accept   = byte_valid && byte_ready;
  assign len_full = {count[HDR_W-1:8], byte_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = (len_full == '0) ? DONE : DATA;
      end
      DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_idx == 2'd3) state_nx = WRITE;
      end
      WRITE: begin
        // Oversized programs are still drained, but words past capacity are dropped.
        imem_we  = int'(word_idx) < MAX_WORDS;
        state_nx = (word_idx + 16'd1 == count) ? DONE : DATA;
      end
      DONE: begin
        if (start) state_nx = LEN_HI;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        LEN_HI: if (accept) count[HDR_W-1:8] <= byte_data;
        LEN_LO: begin
          if (accept) begin
            count[7:0] <= byte_data;
            word_idx   <= '0;
            byte_idx   <= '0;
            err        <= int'(len_full) > MAX_WORDS;
          end
        end
        DATA:  if (accept) byte_idx <= byte_idx + 2'd1;
        WRITE: word_idx <= word_idx + 16'd1;
        DONE:  if (start) err <= 1'b0;
        default: ;
      endcase
    end
  end

  loader_word_asm u_word_asm (
    .clk      (clk),
    .clear    (rst || (state == LEN_LO && accept)),
    .shift_en (state == DATA && accept),
    .byte_in  (byte_data),
    .word     (word)
  );

  assign imem_waddr = BASE_ADDR + {14'b0, word_idx, 2'b00};
  assign imem_wdata = word;
  assign done       = (state == DONE);
  assign cpu_rst    = (state != DONE) || err;
  assign error      = err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a cycle table for the basic two-word load,
// then hand sequences for reload, empty, oversized, gappy and aborted loads.
module tb_imem_loader;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;

  logic        ready0, we0, crst0, done0, err0;
  logic [31:0] a0, d0;
  logic        ready1, we1, crst1, done1, err1;
  logic [31:0] a1, d1;
  logic        ready2, we2, crst2, done2, err2;
  logic [31:0] a2, d2;

  always #5 clk = ~clk;

  imem_loader u0 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready0), .imem_we(we0), .imem_waddr(a0), .imem_wdata(d0),
    .cpu_rst(crst0), .done(done0), .error(err0)
  );

  imem_loader #(.MAX_WORDS(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready1), .imem_we(we1), .imem_waddr(a1), .imem_wdata(d1),
    .cpu_rst(crst1), .done(done1), .error(err1)
  );

  imem_loader #(.BASE_ADDR(32'h0000_0100)) u2 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready2), .imem_we(we2), .imem_waddr(a2), .imem_wdata(d2),
    .cpu_rst(crst2), .done(done2), .error(err2)
  );

  logic [63:0] w0[$];
  logic [63:0] w1[$];
  logic [63:0] w2[$];

  always @(posedge clk) begin
    if (we0) w0.push_back({a0, d0});
    if (we1) w1.push_back({a1, d1});
    if (we2) w2.push_back({a2, d2});
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        exp_ready;
    logic        exp_we;
    logic        exp_done;
    logic        exp_crst;
    logic        chk_aw;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  bq[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic v, input logic [7:0] d, input logic r,
                     input logic we, input logic dn, input logic cr, input logic ca,
                     input logic [31:0] ea, input logic [31:0] ed);
    vec_t t;
    t = '{s, v, d, r, we, dn, cr, ca, ea, ed};
    tbl.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_logs();
    w0.delete();
    w1.delete();
    w2.delete();
  endtask

  // Offers bytes from bq; with gaps, byte_valid is randomised and byte_data is junk when invalid.
  task automatic send(input bit gaps);
    int  k;
    int  cyc;
    bit  acc;
    k = 0;
    cyc = 0;
    while (k < bq.size() && cyc < 2000) begin
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = byte_valid ? bq[k] : 8'($urandom);
      acc = byte_valid && ready0;
      tick();
      if (acc) k++;
      cyc++;
    end
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    chk32("send_all_bytes", 32'(k), 32'(bq.size()));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done0; i++) tick();
    chk1("wait_done", done0, 1'b1);
  endtask

  task automatic push_word(input logic [31:0] w);
    bq.push_back(w[31:24]);
    bq.push_back(w[23:16]);
    bq.push_back(w[15:8]);
    bq.push_back(w[7:0]);
  endtask

  initial begin
    // Basic two-word load, one row per clock; outputs checked after each edge.
    add(H, L, 8'h00, H, L, L, H, L, 32'h0, 32'h0);
    add(L, H, 8'h00, H, L, L, H, L, 32'h0, 32'h0);
    add(L, H, 8'h02, H, L, L, H, H, 32'h0, 32'h0);
    add(H, H, 8'h24, H, L, L, H, L, 32'h0, 32'h0);
    add(L, H, 8'h08, H, L, L, H, L, 32'h0, 32'h0);
    add(L, H, 8'h00, H, L, L, H, L, 32'h0, 32'h0);
    add(L, H, 8'h05, L, H, L, H, H, 32'h0, 32'h2408_0005);
    add(L, H, 8'hAC, H, L, L, H, H, 32'h4, 32'h2408_0005);
    add(L, H, 8'hAC, H, L, L, H, L, 32'h0, 32'h0);
    add(L, H, 8'h08, H, L, L, H, L, 32'h0, 32'h0);
    add(L, H, 8'h00, H, L, L, H, L, 32'h0, 32'h0);
    add(L, H, 8'h00, L, H, L, H, H, 32'h4, 32'hAC08_0000);
    add(L, L, 8'h00, L, L, H, L, L, 32'h0, 32'h0);
    add(L, L, 8'h00, L, L, H, L, L, 32'h0, 32'h0);

    tick();
    chk1("rst_ready", ready0, 1'b0);
    chk1("rst_we", we0, 1'b0);
    chk1("rst_cpu_rst", crst0, 1'b1);
    chk1("rst_done", done0, 1'b0);
    chk1("rst_error", err0, 1'b0);
    chk32("rst_waddr", a0, 32'h0);
    chk32("rst_wdata", d0, 32'h0);
    chk32("rst_waddr_base", a2, 32'h100);
    rst = 1'b0;

    foreach (tbl[i]) begin
      start      = tbl[i].start;
      byte_valid = tbl[i].valid;
      byte_data  = tbl[i].data;
      tick();
      chk1($sformatf("row%0d_ready", i), ready0, tbl[i].exp_ready);
      chk1($sformatf("row%0d_we", i), we0, tbl[i].exp_we);
      chk1($sformatf("row%0d_done", i), done0, tbl[i].exp_done);
      chk1($sformatf("row%0d_cpu_rst", i), crst0, tbl[i].exp_crst);
      if (tbl[i].chk_aw) begin
        chk32($sformatf("row%0d_waddr", i), a0, tbl[i].exp_addr);
        chk32($sformatf("row%0d_wdata", i), d0, tbl[i].exp_data);
        chk32($sformatf("row%0d_waddr_base", i), a2, tbl[i].exp_addr + 32'h100);
      end
    end
    start = 1'b0;
    byte_valid = 1'b0;

    chk32("basic_nwrites", 32'(w0.size()), 32'd2);
    chk32("basic_base_nwrites", 32'(w2.size()), 32'd2);
    if (w2.size() == 2) begin
      chk32("basic_base_a0", w2[0][63:32], 32'h100);
      chk32("basic_base_d0", w2[0][31:0], 32'h2408_0005);
      chk32("basic_base_a1", w2[1][63:32], 32'h104);
      chk32("basic_base_d1", w2[1][31:0], 32'hAC08_0000);
    end

    // Reload from DONE: cpu_rst rises immediately, writes restart at the base.
    clear_logs();
    pulse_start();
    chk1("reload_cpu_rst", crst2, 1'b1);
    chk1("reload_done_clr", done2, 1'b0);
    chk1("reload_cpu_rst0", crst0, 1'b1);
    bq = '{8'h00, 8'h01};
    push_word(32'hDEAD_BEEF);
    send(1'b0);
    wait_done();
    chk32("reload_nwrites", 32'(w2.size()), 32'd1);
    if (w2.size() == 1) begin
      chk32("reload_addr", w2[0][63:32], 32'h100);
      chk32("reload_data", w2[0][31:0], 32'hDEAD_BEEF);
    end
    chk1("reload_cpu_rel", crst0, 1'b0);

    // Empty program.
    clear_logs();
    pulse_start();
    bq = '{8'h00, 8'h00};
    send(1'b0);
    wait_done();
    chk32("empty_nwrites", 32'(w0.size()), 32'd0);
    chk1("empty_cpu_rst", crst0, 1'b0);
    chk1("empty_error", err0, 1'b0);

    // Oversized header on the 2-word instance.
    clear_logs();
    pulse_start();
    bq = '{8'h00, 8'h03};
    send(1'b0);
    chk1("big_error_at_hdr", err1, 1'b1);
    chk1("small_no_error", err0, 1'b0);
    bq.delete();
    push_word(32'h1122_3344);
    push_word(32'h5566_7788);
    push_word(32'h99AA_BBCC);
    send(1'b0);
    wait_done();
    chk1("big_done", done1, 1'b1);
    chk1("big_error", err1, 1'b1);
    chk1("big_cpu_rst", crst1, 1'b1);
    chk32("big_nwrites", 32'(w1.size()), 32'd2);
    if (w1.size() == 2) chk32("big_last", w1[1][31:0], 32'h5566_7788);
    chk32("full_nwrites", 32'(w0.size()), 32'd3);
    if (w0.size() == 3) chk32("full_last", w0[2][31:0], 32'h99AA_BBCC);

    // Three words with random byte_valid gaps.
    clear_logs();
    pulse_start();
    chk1("restart_clears_error", err1, 1'b0);
    bq = '{8'h00, 8'h03};
    push_word(32'h0123_4567);
    push_word(32'h89AB_CDEF);
    push_word(32'h0F1E_2D3C);
    send(1'b1);
    wait_done();
    chk32("gap_nwrites", 32'(w0.size()), 32'd3);
    if (w0.size() == 3) begin
      chk32("gap_d0", w0[0][31:0], 32'h0123_4567);
      chk32("gap_d1", w0[1][31:0], 32'h89AB_CDEF);
      chk32("gap_d2", w0[2][31:0], 32'h0F1E_2D3C);
      chk32("gap_a2", w0[2][63:32], 32'h8);
    end

    // Reset mid-word, then a clean full load.
    clear_logs();
    pulse_start();
    bq = '{8'h00, 8'h02};
    push_word(32'hA1A2_A3A4);
    bq.push_back(8'hB1);
    bq.push_back(8'hB2);
    send(1'b0);
    byte_valid = 1'b1;
    byte_data  = 8'hB3;
    start = 1'b1;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    chk1("abort_ready", ready0, 1'b0);
    chk1("abort_cpu_rst", crst0, 1'b1);
    chk1("abort_done", done0, 1'b0);
    chk32("abort_waddr", a0, 32'h0);
    chk32("abort_wdata", d0, 32'h0);
    tick();
    chk1("abort_stays_idle", ready0, 1'b0);
    chk32("abort_nwrites", 32'(w0.size()), 32'd1);
    pulse_start();
    bq = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    send(1'b0);
    wait_done();
    chk32("after_abort_nwrites", 32'(w0.size()), 32'd3);
    if (w0.size() == 3) begin
      chk32("after_abort_a1", w0[1][63:32], 32'h0);
      chk32("after_abort_d1", w0[1][31:0], 32'h2408_0005);
      chk32("after_abort_a2", w0[2][63:32], 32'h4);
      chk32("after_abort_d2", w0[2][31:0], 32'hAC08_0000);
    end
    chk1("after_abort_cpu_rst", crst0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter: MAX_WORDS, 256, instruction-memory capacity in 32-bit words.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  one-cycle pulse that begins a program load.
REQ-006 Port: byte_valid  input  1  byte_data holds a valid stream byte.
REQ-007 Port: byte_data  input  8  program stream byte.
REQ-008 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 Port: imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 Port: imem_waddr  output  32  word-aligned byte address for the write.
REQ-011 Port: imem_wdata  output  32  instruction word to write.
REQ-012 Port: cpu_rst  output  1  holds the datapath in reset while no valid program is loaded.
REQ-013 Port: done  output  1  load complete; the program is resident.
REQ-014 Port: error  output  1  the length header exceeded MAX_WORDS.

Function
REQ-015 A byte SHALL transfer only on a cycle with byte_valid=1 and byte_ready=1; byte_data SHALL be ignored on any other cycle.
REQ-016 Stream format SHALL be: a 16-bit word count N, high byte first, then N words of 4 bytes each, most significant byte first (big-endian, MIPS order).
REQ-017 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE and DONE.
REQ-018 IDLE: byte_ready=0. start=1 SHALL move to LEN_HI.
REQ-019 LEN_HI and LEN_LO: byte_ready=1. Each accepted byte is captured into the count register and SHALL advance the state.
REQ-020 After LEN_LO accepts its byte: N=0 SHALL go to DONE; otherwise the word index and byte index SHALL clear to 0 and the state SHALL go to DATA.
REQ-021 DATA: byte_ready=1. Each accepted byte SHALL shift left into the word register. The 4th accepted byte SHALL move to WRITE.
REQ-022 WRITE SHALL last exactly 1 cycle with byte_ready=0. In that cycle:
- imem_we=1 only if the word index < MAX_WORDS;
- imem_waddr = BASE_ADDR + 4*index;
- imem_wdata = the assembled word.
REQ-023 After WRITE the word index SHALL increment. If the index+1 == N the state SHALL go to DONE; otherwise it SHALL go back to DATA.
REQ-024 Latency: imem_we SHALL assert in the cycle immediately after the 4th byte of a word is accepted.
REQ-025 If N > MAX_WORDS, error SHALL set when LEN_LO completes. All N words SHALL still be consumed, but only the first MAX_WORDS SHALL be written.
REQ-026 The word index SHALL be 16 bits wide. The address arithmetic SHALL be 32-bit and wrap modulo 2^32.
REQ-027 DONE: done=1, cpu_rst=0 (or cpu_rst=1 if error=1), byte_ready=0.
REQ-028 A start pulse in DONE SHALL clear done and error, set cpu_rst=1, and go to LEN_HI.
REQ-029 start SHALL be ignored in every state other than IDLE and DONE.
REQ-030 imem_we SHALL be 0 in every state except WRITE.
REQ-031 cpu_rst SHALL be 1 in every state except DONE.

Reset
REQ-032 With rst=1 at a clock edge, the next state SHALL be:
- state = IDLE;
- byte_ready = 0, imem_we = 0;
- imem_waddr = BASE_ADDR, imem_wdata = 0;
- cpu_rst = 1, done = 0, error = 0;
- all counters = 0.
REQ-033 Reset SHALL take priority over start and over any byte transfer in the same cycle.
REQ-034 Reset mid-load SHALL abandon the load; words already written SHALL remain in memory.

Structure
REQ-035 The state encoding and the stream header width (16) SHALL be defined in the shared package mips_pkg.
REQ-036 Byte-to-word assembly SHALL be a sub-module, loader_word_asm, with shift-enable, clear and a 32-bit word output. Everything else SHALL be flat.

Verification
REQ-037 Reset, then start, then stream 00 02 24 08 00 05 AC 08 00 00 with byte_valid held high -> two writes:
- 0x24080005 to address 0x0;
- 0xAC080000 to address 0x4;
- then done=1 and cpu_rst=0.
REQ-038 Stream 00 00 -> DONE is reached with no imem_we pulse and done=1.
REQ-039 MAX_WORDS=2, header 00 03 followed by 12 bytes -> error=1, exactly 2 writes, and cpu_rst stays 1.
REQ-040 byte_valid toggling randomly during a 3-word load -> the words are identical to those of a gap-free load, and no byte is lost or duplicated.
REQ-041 rst asserted after the 2nd byte of word 1 -> next cycle is IDLE with cpu_rst=1; a subsequent full load is correct.
REQ-042 start pulsed in DONE with BASE_ADDR=0x100 -> cpu_rst rises; the reload writes begin at 0x100.
